// File: rtl/package_settings.sv
// Global data-path settings shared by the v4 processing chain.
//   SIZE_FILTER_DATA : width of the shaped samples produced by the
//                      trapezoidal filter (two's-complement signed).
package package_settings;

    localparam int SIZE_FILTER_DATA = 16;

endpackage

// File: rtl/v4_parameters.sv
// Defaults and shared types for the v4 peak detector.
//   DEF_*   : default values for the peak detector parameters
//   state_t : pulse-finding FSM state encoding
package v4_parameters;

    localparam int DEF_THRESHOLD = 100;
    localparam int DEF_MIN_WIDTH = 4;
    localparam int DEF_MAX_WIDTH = 64;
    localparam int DEF_HOLDOFF   = 16;
    localparam int DEF_TS_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH = 16;

    // ST_HOLDOFF is the dead-time state; the ST_ prefix keeps the state
    // names distinct from the parameter names of the detector.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/v4_event_register.sv
// Output event register of the peak detector.
// Holds one event toward the consumer and decides whether a newly posted
// event is loaded or dropped; counts dropped events (saturating).
//
// Handshake: an event transfers on a rising edge where event_valid and
// event_ready are both 1. While event_valid && !event_ready, the held
// contents stay stable. A post is accepted when the register is empty or
// is being emptied in the same cycle; otherwise it is dropped.
//
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   post              : a new event is offered this cycle
//   post_amplitude    : peak value of the offered event
//   post_time         : timestamp of the offered peak
//   post_pileup       : pile-up flag of the offered event
//   event_ready       : consumer accepts the held event
//   event_valid       : an event is held
//   event_amplitude   : held peak value
//   event_time        : held timestamp
//   event_pileup      : held pile-up flag
//   lost_count        : number of dropped events, saturating at all-ones
module v4_event_register #(
    parameter int DATA_WIDTH = 16,
    parameter int TS_WIDTH   = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         post,
    input  logic signed [DATA_WIDTH-1:0] post_amplitude,
    input  logic        [TS_WIDTH-1:0]   post_time,
    input  logic                         post_pileup,
    input  logic                         event_ready,
    output logic                         event_valid,
    output logic signed [DATA_WIDTH-1:0] event_amplitude,
    output logic        [TS_WIDTH-1:0]   event_time,
    output logic                         event_pileup,
    output logic        [CNT_WIDTH-1:0]  lost_count
);

    logic can_load;

    // Free slot: empty now, or the held event leaves on this same edge.
    assign can_load = !event_valid || event_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            event_valid     <= 1'b0;
            event_amplitude <= '0;
            event_time      <= '0;
            event_pileup    <= 1'b0;
            lost_count      <= '0;
        end else if (post) begin
            if (can_load) begin
                event_valid     <= 1'b1;
                event_amplitude <= post_amplitude;
                event_time      <= post_time;
                event_pileup    <= post_pileup;
            end else if (lost_count != '1) begin
                lost_count <= lost_count + 1'b1;
            end
        end else if (event_valid && event_ready) begin
            event_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/v4_peak_detector.sv
// Pulse-height analyser behind the v4 trapezoidal shaping filter.
// Registers each shaped sample with a free-running timestamp, finds pulses
// above THRESHOLD, tracks the peak value and its timestamp, and posts one
// event per pulse of at least MIN_WIDTH samples. Pulses longer than
// MAX_WIDTH samples are flagged pile-up. After a reported pulse the input
// is ignored for HOLDOFF cycles.
//
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   input_data       : shaped sample, signed, one per clock
//   event_valid      : event available (valid/ready toward readout)
//   event_ready      : consumer accepts the event this cycle
//   event_amplitude  : peak value (signed)
//   event_time       : timestamp of the peak sample
//   event_pileup     : pulse width exceeded MAX_WIDTH
//   lost_count       : events dropped due to backpressure, saturating
module v4_peak_detector
    import package_settings::*;
    import v4_parameters::*;
#(
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int MIN_WIDTH = DEF_MIN_WIDTH,
    parameter int MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int HOLDOFF   = DEF_HOLDOFF,
    parameter int TS_WIDTH  = DEF_TS_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    output logic                               event_valid,
    input  logic                               event_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] event_amplitude,
    output logic        [TS_WIDTH-1:0]         event_time,
    output logic                               event_pileup,
    output logic        [CNT_WIDTH-1:0]        lost_count
);

    localparam int DW = SIZE_FILTER_DATA;
    // Width counter saturates at MAX_WIDTH+1, which is enough to know
    // both "long enough" and "too long".
    localparam int WW = $clog2(MAX_WIDTH + 2);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic signed [DW-1:0] TH_S      = DW'(THRESHOLD);
    localparam logic        [WW-1:0] MIN_W     = WW'(MIN_WIDTH);
    localparam logic        [WW-1:0] MAX_W     = WW'(MAX_WIDTH);
    localparam logic        [WW-1:0] WIDTH_SAT = WW'(MAX_WIDTH + 1);
    localparam logic        [HW-1:0] HOLD_INIT = HW'(HOLDOFF);

    logic        [TS_WIDTH-1:0] ts;
    logic signed [DW-1:0]       x;
    logic        [TS_WIDTH-1:0] x_ts;

    state_t                     state;
    logic signed [DW-1:0]       peak;
    logic        [TS_WIDTH-1:0] peak_ts;
    logic        [WW-1:0]       width;
    logic        [HW-1:0]       hold_cnt;

    logic above;
    logic post;
    logic post_pileup;

    assign above       = (x >= TH_S);
    // The pulse ends on the first below-threshold sample; it is reported
    // on that same edge so the event register loads one edge later than x.
    assign post        = (state == ST_PULSE) && !above && (width >= MIN_W);
    assign post_pileup = (width > MAX_W);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ts       <= '0;
            x        <= '0;
            x_ts     <= '0;
            state    <= ST_IDLE;
            peak     <= '0;
            peak_ts  <= '0;
            width    <= '0;
            hold_cnt <= '0;
        end else begin
            ts   <= ts + 1'b1;
            x    <= input_data;
            x_ts <= ts;

            case (state)
                ST_IDLE: begin
                    if (above) begin
                        state   <= ST_PULSE;
                        peak    <= x;
                        peak_ts <= x_ts;
                        width   <= WW'(1);
                    end
                end

                ST_PULSE: begin
                    if (above) begin
                        if (width != WIDTH_SAT) begin
                            width <= width + 1'b1;
                        end
                        // Strict compare keeps the earliest of equal peaks.
                        if (x > peak) begin
                            peak    <= x;
                            peak_ts <= x_ts;
                        end
                    end else if (width < MIN_W) begin
                        state <= ST_IDLE;
                    end else if (HOLDOFF == 0) begin
                        state <= ST_IDLE;
                    end else begin
                        state    <= ST_HOLDOFF;
                        hold_cnt <= HOLD_INIT;
                    end
                end

                ST_HOLDOFF: begin
                    // Samples are ignored here; leave when the count hits 0.
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt <= HW'(1)) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    v4_event_register #(
        .DATA_WIDTH (DW),
        .TS_WIDTH   (TS_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_event_register (
        .clk             (clk),
        .reset           (reset),
        .post            (post),
        .post_amplitude  (peak),
        .post_time       (peak_ts),
        .post_pileup     (post_pileup),
        .event_ready     (event_ready),
        .event_valid     (event_valid),
        .event_amplitude (event_amplitude),
        .event_time      (event_time),
        .event_pileup    (event_pileup),
        .lost_count      (lost_count)
    );

endmodule

// File: tb/tb_v4_peak_detector.sv
// Self-checking bench for v4_peak_detector: directed pulses plus random
// pulse trains, checked against a pulse-level reference model and an
// expected-event queue.
module tb_v4_peak_detector;
    import package_settings::*;
    import v4_parameters::*;

    localparam int DW = SIZE_FILTER_DATA;
    localparam int TW = DEF_TS_WIDTH;
    localparam int CW = DEF_CNT_WIDTH;
    localparam int EW = DW + TW + 1;
    localparam int LOST_MAX = (1 << CW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk;
    logic                 reset;
    logic signed [DW-1:0] input_data;
    logic                 event_valid;
    logic                 event_ready;
    logic signed [DW-1:0] event_amplitude;
    logic        [TW-1:0] event_time;
    logic                 event_pileup;
    logic        [CW-1:0] lost_count;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    v4_peak_detector dut (
        .clk             (clk),
        .reset           (reset),
        .input_data      (input_data),
        .event_valid     (event_valid),
        .event_ready     (event_ready),
        .event_amplitude (event_amplitude),
        .event_time      (event_time),
        .event_pileup    (event_pileup),
        .lost_count      (lost_count)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Works on whole pulses: collects above-threshold samples of the
    // current pulse, and at its end picks the first maximum.
    logic [EW-1:0] exp_q[$];
    int            pv[$];
    int unsigned   pt[$];
    int unsigned   ts_m      = 0;
    int            x_m       = 0;
    int unsigned   xts_m     = 0;
    int            hold_left = 0;
    bit            v_m       = 1'b0;
    int            lost_m    = 0;
    bit            rst_seen  = 1'b0;

    always @(posedge clk) begin
        bit                   post;
        logic [EW-1:0]        pkt;
        int                   best;
        logic signed [DW-1:0] amp_v;
        logic        [TW-1:0] ts_v;
        if (!reset) begin
            ts_m = 0; x_m = 0; xts_m = 0; hold_left = 0;
            v_m = 1'b0; lost_m = 0; rst_seen = 1'b1;
            pv.delete(); pt.delete(); exp_q.delete();
        end else begin
            rst_seen = 1'b0;
            post = 1'b0;
            pkt = '0;
            if (hold_left > 0) begin
                hold_left--;
            end else if (x_m >= DEF_THRESHOLD) begin
                pv.push_back(x_m);
                pt.push_back(xts_m);
            end else if (pv.size() > 0) begin
                if (pv.size() >= DEF_MIN_WIDTH) begin
                    best = 0;
                    for (int i = 1; i < pv.size(); i++)
                        if (pv[i] > pv[best]) best = i;
                    amp_v = DW'(pv[best]);
                    ts_v  = TW'(pt[best]);
                    pkt   = {amp_v, ts_v, (pv.size() > DEF_MAX_WIDTH)};
                    post  = 1'b1;
                    hold_left = DEF_HOLDOFF;
                end
                pv.delete(); pt.delete();
            end
            if (post) begin
                if (!v_m || event_ready) begin
                    v_m = 1'b1;
                    exp_q.push_back(pkt);
                end else if (lost_m < LOST_MAX) begin
                    lost_m++;
                end
            end else if (v_m && event_ready) begin
                v_m = 1'b0;
            end
            x_m   = int'(input_data);
            xts_m = ts_m;
            ts_m++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_seen) begin
            check("reset_valid",     64'(event_valid), 64'(0));
            check("reset_amplitude", 64'(event_amplitude), 64'(0));
            check("reset_time",      64'(event_time), 64'(0));
            check("reset_pileup",    64'(event_pileup), 64'(0));
            check("reset_lost",      64'(lost_count), 64'(0));
        end else begin
            check("event_valid", 64'(event_valid), 64'(v_m));
            check("lost_count",  64'(lost_count), 64'(lost_m));
        end
        if (reset && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("amplitude", 64'($signed(event_amplitude)), 64'($signed(e[EW-1 -: DW])));
                check("event_time", 64'(event_time), 64'(e[TW:1]));
                check("pileup", 64'(event_pileup), 64'(e[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int s, input bit r, input bit rst_n);
        input_data  = DW'(s);
        event_ready = r;
        reset       = rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic flat(input int s, input int n, input bit r);
        for (int i = 0; i < n; i++) drive(s, r, 1'b1);
    endtask

    task automatic random_pulse();
        int gap, w;
        gap = $urandom_range(0, 25);
        for (int i = 0; i < gap; i++)
            drive(int'($urandom_range(0, 399)) - 300, ($urandom_range(0, 3) != 0), 1'b1);
        w = ($urandom_range(0, 7) == 0) ? $urandom_range(66, 72) : $urandom_range(1, 12);
        for (int i = 0; i < w; i++)
            drive(DEF_THRESHOLD + int'($urandom_range(0, 500)), ($urandom_range(0, 3) != 0), 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        input_data  = '0;
        event_ready = 1'b1;
        reset       = 1'b0;

        for (int i = 0; i < 5; i++) drive(0, 1'b1, 1'b0);

        // Quiet input: no events, counter runs.
        flat(0, 200, 1'b1);

        // Trapezoid up to 500 and back.
        drive(0, 1'b1, 1'b1);
        for (int v = 50; v <= 500; v += 50) drive(v, 1'b1, 1'b1);
        flat(500, 10, 1'b1);
        for (int v = 450; v >= 0; v -= 50) drive(v, 1'b1, 1'b1);
        flat(0, 30, 1'b1);

        // Too narrow, then just wide enough.
        flat(300, 3, 1'b1);
        flat(0, 30, 1'b1);
        flat(300, 4, 1'b1);
        flat(0, 30, 1'b1);

        // Backpressure: second event dropped, first held.
        flat(300, 6, 1'b0);
        flat(0, 40, 1'b0);
        flat(300, 6, 1'b0);
        flat(0, 25, 1'b0);
        drive(0, 1'b1, 1'b1);
        flat(0, 10, 1'b0);
        flat(0, 10, 1'b1);

        // Pile-up pulse, then a pulse inside the dead time.
        flat(250, 80, 1'b1);
        flat(0, 5, 1'b1);
        flat(300, 8, 1'b1);
        flat(0, 30, 1'b1);

        // Reset in the middle of a pulse, then a fresh pulse.
        flat(500, 5, 1'b1);
        drive(500, 1'b1, 1'b0);
        flat(0, 5, 1'b1);
        flat(400, 6, 1'b1);
        flat(0, 30, 1'b1);

        // Threshold boundary: exactly THRESHOLD counts as above.
        flat(DEF_THRESHOLD - 1, 6, 1'b1);
        flat(DEF_THRESHOLD, 4, 1'b1);
        flat(DEF_THRESHOLD - 1, 30, 1'b1);

        // Random pulse trains with random backpressure.
        for (int k = 0; k < 60; k++) random_pulse();

        // Drain.
        flat(0, 100, 1'b1);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
